lcd_access_arbiter: RTL and testbench
=====================================

Name: lcd_access_arbiter

Overview:
- Shares the single LCD byte-write controller (data/send/rs/rw in, done out) among NREQ command sources, e.g. configuration, message writer and cursor/blink timer.
- Uses round-robin arbitration and issues one byte per grant.
- Enforces the HD44780 post-command settle time in a local gap counter, so requesters never track LCD timing.
- Sits between the central sequencer's sources and the LCD controller.

Parameters:
- NREQ, 3, number of requesters (2..4).
- GAP_CYCLES, 2000, idle cycles after a normal command (40 us at 50 MHz).
- LONG_GAP_CYCLES, 82000, idle cycles after clear or return-home (1.64 ms at 50 MHz).
- TIMEOUT_CYCLES, 1000000, done-wait limit; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  NREQ  request per source; level, held until ack.
- req_data  in  8*NREQ  command/char byte; source i uses bits [8i+7:8i].
- req_rs  in  NREQ  register select per source; 0 = instruction, 1 = data.
- ack  out  NREQ  one-cycle pulse to the granted source when its byte completes.
- grant_id  out  2  index of the current or last granted source.
- busy  out  1  high in every state except IDLE.
- lcd_data  out  8  byte to LCD controller.
- lcd_rs  out  1  register select to controller.
- lcd_rw  out  1  always 0 (write-only).
- lcd_send  out  1  one-cycle start pulse to controller.
- lcd_done  in  1  controller completion pulse.
- timeout_err  out  1  sticky timeout flag (tied 0 without the optional feature).

Behaviour:
- Reset, asynchronous: state = IDLE. All outputs = 0 (ack, grant_id, busy, lcd_data, lcd_rs, lcd_rw, lcd_send, timeout_err). RR pointer = 0. Gap counter = 0.
- Reset mid-operation aborts any byte in flight with no ack. The controller is expected to be reset by the same reset.
- IDLE:
  - Selects the first asserted req starting at the RR pointer, wrapping modulo NREQ.
  - On a hit, registers grant_id, lcd_data and lcd_rs from the winner, then goes to ISSUE.
  - RR pointer becomes (winner + 1) mod NREQ.
  - No req: stay in IDLE.
- ISSUE: lcd_send = 1 for exactly this cycle, then WAIT_DONE.
  - Latency: req seen high at edge N gives lcd_send high in cycle N+1.
- WAIT_DONE:
  - lcd_done is ignored in the ISSUE cycle and honoured from the next cycle on.
  - On lcd_done: ack[grant_id] = 1 for one cycle.
  - Gap counter loads LONG_GAP_CYCLES if lcd_rs = 0 and lcd_data is 0x01, 0x02 or 0x03; otherwise it loads GAP_CYCLES. Then go to GAP.
- GAP:
  - Counter decrements each cycle; at 0, go to IDLE.
  - A gap of G therefore gives G cycles in GAP, then one arbitration cycle in IDLE.
  - lcd_done in IDLE or GAP is ignored.
- lcd_data and lcd_rs stay stable from ISSUE until the next grant; the controller may sample them at any point.
- Request rules:
  - A req dropped before grant is never served.
  - A req dropped after grant still completes and still receives ack.
  - Data changes after grant are ignored, because the byte is captured at grant.
- Simultaneous requests: RR order only, no fixed priority. With all sources asserted continuously, grants cycle 0, 1, 2, 0, and so on.
- A source that re-asserts req the cycle after its ack waits behind the other pending sources.

Optional Feature:
- Macro: LCD_ARB_TIMEOUT_EN.
- With the macro:
  - A counter runs in WAIT_DONE. If it reaches TIMEOUT_CYCLES with no lcd_done, ack[grant_id] still pulses, so the source does not hang.
  - timeout_err is set and stays high until reset.
  - The gap counter loads LONG_GAP_CYCLES, then the block goes to GAP.
- Without the macro: WAIT_DONE waits indefinitely; timeout_err is tied 0 and no counter is built.

Decomposition:
- Package lcd_arb_pkg holds:
  - state encoding (IDLE, ISSUE, WAIT_DONE, GAP);
  - opcodes LCD_CLEAR = 8'h01 and LCD_HOME = 8'h02;
  - default gap and timeout constants;
  - a command struct {rs, data}.
- One sub-module: lcd_rr_picker, a combinational round-robin picker with inputs req and pointer and outputs hit and index. Registers stay in the parent.

Test Plan:
All scenarios use GAP_CYCLES = 4, LONG_GAP_CYCLES = 20, TIMEOUT_CYCLES = 50, and a controller model that returns done 3 cycles after send.
1. Single request: req[1] high, data 8'h41, rs 1 → lcd_send one cycle later with lcd_data 8'h41 and lcd_rs 1; ack[1] pulses once; busy low 4 cycles after ack plus the IDLE cycle.
2. Fairness: req = 3'b111 held for 6 commands → grant_id sequence 0, 1, 2, 0, 1, 2; each ack is exactly one pulse.
3. Long gap: source 0 sends rs 0, data 8'h01 → 20 GAP cycles before the next lcd_send; rs 0, data 8'h38 → 4 GAP cycles.
4. Late drop and early drop:
   - req[2] dropped the cycle after grant → byte still sent, ack[2] still pulses.
   - req[0] dropped before grant → never sent.
5. Mid-operation reset: reset asserted during WAIT_DONE → all outputs 0 asynchronously, no ack; after release, req[2] alone is granted first (pointer = 0 scan).
6. Timeout, with LCD_ARB_TIMEOUT_EN: controller never returns done → ack pulses 50 cycles after WAIT_DONE entry, timeout_err stays 1, then a 20-cycle gap. Without the macro: no ack and busy stays high.

Source files
------------

// File: rtl/lcd_access_arbiter_pkg.sv
// Shared types and constants for the LCD access arbiter.
// States, HD44780 opcodes that need the long settle time, and default timing constants.
package lcd_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } state_t;

    localparam logic [7:0] LCD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_HOME  = 8'h02;

    localparam int DEF_NREQ            = 3;
    localparam int DEF_GAP_CYCLES      = 2000;
    localparam int DEF_LONG_GAP_CYCLES = 82000;
    localparam int DEF_TIMEOUT_CYCLES  = 1000000;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } cmd_t;

    // 0x03 is return-home with the don't-care bit set, so it settles as long as 0x02.
    function automatic logic is_long_cmd(input cmd_t c);
        return !c.rs && (c.data == LCD_CLEAR || c.data == LCD_HOME || c.data == 8'h03);
    endfunction

endpackage

// File: rtl/lcd_access_arbiter_if.sv
// Requester and LCD-controller signal bundle for the arbiter.
// master = arbiter side, slave = requesters plus controller side.
interface lcd_arb_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_rs;
    logic [NREQ-1:0]   ack;
    logic [1:0]        grant_id;
    logic              busy;
    logic [7:0]        lcd_data;
    logic              lcd_rs;
    logic              lcd_rw;
    logic              lcd_send;
    logic              lcd_done;
    logic              timeout_err;

    modport master (
        input  req, req_data, req_rs, lcd_done,
        output ack, grant_id, busy, lcd_data, lcd_rs, lcd_rw, lcd_send, timeout_err
    );

    modport slave (
        output req, req_data, req_rs, lcd_done,
        input  ack, grant_id, busy, lcd_data, lcd_rs, lcd_rw, lcd_send, timeout_err
    );
endinterface

// File: rtl/lcd_access_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after the pointer,
// wrapping modulo NREQ.
module lcd_rr_picker #(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [1:0]      i_ptr,
    output logic            o_hit,
    output logic [1:0]      o_idx
);
    logic [1:0] w_cand [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
        assign w_cand[gi] = 2'((32'(i_ptr) + gi) % NREQ);
    end

    // Scan from the far end so the candidate closest to the pointer wins.
    always_comb begin
        o_hit = 1'b0;
        o_idx = 2'd0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (i_req[w_cand[k]]) begin
                o_hit = 1'b1;
                o_idx = w_cand[k];
            end
        end
    end
endmodule

// File: rtl/lcd_access_arbiter.sv
// Round-robin arbiter sharing one LCD byte-write controller, with post-command settle gap.
// Optional done-wait timeout enabled by defining LCD_ARB_TIMEOUT_EN.
module lcd_access_arbiter
    import lcd_arb_pkg::*;
#(
    parameter int NREQ            = DEF_NREQ,
    parameter int GAP_CYCLES      = DEF_GAP_CYCLES,
    parameter int LONG_GAP_CYCLES = DEF_LONG_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic      clk,
    input  logic      reset,
    lcd_arb_if.master bus
);
    localparam int GW = $clog2(LONG_GAP_CYCLES + 1);

    state_t          r_state, w_state_next;
    logic [1:0]      r_ptr, w_ptr_next;
    logic [1:0]      r_grant, w_grant_next;
    cmd_t            r_cmd, w_cmd_next;
    logic [NREQ-1:0] r_ack, w_ack_next;
    logic [GW-1:0]   r_gap, w_gap_next;
`ifdef LCD_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]   r_tmo, w_tmo_next;
    logic            r_tmo_err, w_tmo_err_next;
`endif

    logic       w_hit;
    logic [1:0] w_idx;
    logic [1:0] w_ptr_inc;
    logic [7:0] w_src_data [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_src
        assign w_src_data[gi] = bus.req_data[8*gi +: 8];
    end

    lcd_rr_picker #(.NREQ(NREQ)) u_picker (
        .i_req (bus.req),
        .i_ptr (r_ptr),
        .o_hit (w_hit),
        .o_idx (w_idx)
    );

    assign w_ptr_inc = (w_idx == 2'(NREQ - 1)) ? 2'd0 : w_idx + 2'd1;

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_grant_next = r_grant;
        w_cmd_next   = r_cmd;
        w_ack_next   = '0;
        w_gap_next   = r_gap;
`ifdef LCD_ARB_TIMEOUT_EN
        w_tmo_next     = r_tmo;
        w_tmo_err_next = r_tmo_err;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_hit) begin
                    w_grant_next    = w_idx;
                    w_cmd_next.rs   = bus.req_rs[w_idx];
                    w_cmd_next.data = w_src_data[w_idx];
                    w_ptr_next      = w_ptr_inc;
                    w_state_next    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
`ifdef LCD_ARB_TIMEOUT_EN
                w_tmo_next = '0;
`endif
                w_state_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (bus.lcd_done) begin
                    w_ack_next[r_grant] = 1'b1;
                    w_gap_next   = is_long_cmd(r_cmd) ? GW'(LONG_GAP_CYCLES) : GW'(GAP_CYCLES);
                    w_state_next = ST_GAP;
                end
`ifdef LCD_ARB_TIMEOUT_EN
                // Release the source anyway and assume the worst-case settle time.
                else if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_ack_next[r_grant] = 1'b1;
                    w_tmo_err_next = 1'b1;
                    w_gap_next     = GW'(LONG_GAP_CYCLES);
                    w_state_next   = ST_GAP;
                end else begin
                    w_tmo_next = r_tmo + TW'(1);
                end
`endif
            end
            ST_GAP: begin
                if (r_gap <= GW'(1)) begin
                    w_gap_next   = '0;
                    w_state_next = ST_IDLE;
                end else begin
                    w_gap_next = r_gap - GW'(1);
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
            r_cmd   <= '0;
            r_ack   <= '0;
            r_gap   <= '0;
`ifdef LCD_ARB_TIMEOUT_EN
            r_tmo     <= '0;
            r_tmo_err <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            r_grant <= w_grant_next;
            r_cmd   <= w_cmd_next;
            r_ack   <= w_ack_next;
            r_gap   <= w_gap_next;
`ifdef LCD_ARB_TIMEOUT_EN
            r_tmo     <= w_tmo_next;
            r_tmo_err <= w_tmo_err_next;
`endif
        end
    end

    assign bus.ack      = r_ack;
    assign bus.grant_id = r_grant;
    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.lcd_data = r_cmd.data;
    assign bus.lcd_rs   = r_cmd.rs;
    assign bus.lcd_rw   = 1'b0;
    assign bus.lcd_send = (r_state == ST_ISSUE);
`ifdef LCD_ARB_TIMEOUT_EN
    assign bus.timeout_err = r_tmo_err;
`else
    assign bus.timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_lcd_access_arbiter.sv
// Directed self-checking bench for lcd_access_arbiter (GAP=4, LONG_GAP=20, TIMEOUT=50).
// Controller model returns done 3 cycles after each send unless ctrl_en is low.
module tb_lcd_access_arbiter;

    logic clk = 1'b0;
    logic reset;
    logic ctrl_en;
    logic [2:0] d_pipe;
    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    lcd_arb_if #(.NREQ(3)) bus ();

    lcd_access_arbiter #(
        .NREQ            (3),
        .GAP_CYCLES      (4),
        .LONG_GAP_CYCLES (20),
        .TIMEOUT_CYCLES  (50)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always @(posedge clk or posedge reset) begin
        if (reset) d_pipe <= '0;
        else       d_pipe <= {d_pipe[1:0], bus.lcd_send & ctrl_en};
    end
    assign bus.lcd_done = d_pipe[2];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end else begin
            $display("ok   %s = %0h", tag, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_send(input int lim, output int n);
        n = -1;
        for (int i = 1; i <= lim; i++) begin
            tick();
            if (bus.lcd_send === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_ack(input int lim, output int n);
        n = -1;
        for (int i = 1; i <= lim; i++) begin
            tick();
            if (bus.ack !== 3'b000) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int lim, output int n);
        n = -1;
        for (int i = 1; i <= lim; i++) begin
            tick();
            if (bus.busy === 1'b0) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    logic [8:0] t3_cmd [5];
    int         t3_gap [5];

    initial begin
        int n;
        int cnt;
        logic [1:0] exp_id;

        reset = 1'b1;
        ctrl_en = 1'b1;
        bus.req = '0;
        bus.req_data = '0;
        bus.req_rs = '0;
        t3_cmd = '{9'h001, 9'h038, 9'h101, 9'h003, 9'h002};
        t3_gap = '{20, 4, 4, 20, 20};
        tick();
        tick();

        chk("rst_busy", bus.busy, 0);
        chk("rst_ack", bus.ack, 0);
        chk("rst_grant", bus.grant_id, 0);
        chk("rst_data", bus.lcd_data, 0);
        chk("rst_rs", bus.lcd_rs, 0);
        chk("rst_rw", bus.lcd_rw, 0);
        chk("rst_send", bus.lcd_send, 0);
        chk("rst_tmo", bus.timeout_err, 0);
        reset = 1'b0;
        tick();

        // 1: single request from source 1
        bus.req_data = {8'h00, 8'h41, 8'h00};
        bus.req_rs = 3'b010;
        bus.req = 3'b010;
        wait_send(10, n);
        chk("t1_send_lat", n, 1);
        chk("t1_data", bus.lcd_data, 8'h41);
        chk("t1_rs", bus.lcd_rs, 1);
        chk("t1_grant", bus.grant_id, 1);
        chk("t1_busy", bus.busy, 1);
        tick();
        chk("t1_send_1cyc", bus.lcd_send, 0);
        wait_ack(10, n);
        chk("t1_ack_lat", n, 3);
        chk("t1_ack", bus.ack, 3'b010);
        bus.req = '0;
        tick();
        chk("t1_ack_1cyc", bus.ack, 0);
        wait_idle(10, n);
        chk("t1_gap", n, 3);
        tick();
        chk("t1_stay_idle", bus.busy, 0);

        // 2: fairness with all sources held
        do_reset();
        bus.req_data = {8'h32, 8'h31, 8'h30};
        bus.req_rs = 3'b111;
        bus.req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            exp_id = 2'(k % 3);
            wait_send(40, n);
            chk("t2_sent", n > 0, 1);
            chk("t2_grant", bus.grant_id, exp_id);
            chk("t2_data", bus.lcd_data, 8'h30 + exp_id);
            wait_ack(10, n);
            chk("t2_ack", bus.ack, 3'b001 << exp_id);
            if (k == 5) bus.req = '0;
            tick();
            chk("t2_ack_1cyc", bus.ack, 0);
        end
        wait_idle(40, n);
        chk("t2_idle", n > 0, 1);

        // 3: short and long settle gaps from source 0
        bus.req_rs[0] = t3_cmd[0][8];
        bus.req_data[7:0] = t3_cmd[0][7:0];
        bus.req = 3'b001;
        wait_send(10, n);
        chk("t3_first", n, 1);
        for (int i = 0; i < 5; i++) begin
            chk("t3_data", bus.lcd_data, t3_cmd[i][7:0]);
            chk("t3_rs", bus.lcd_rs, t3_cmd[i][8]);
            wait_ack(10, n);
            chk("t3_ack_lat", n, 4);
            if (i < 4) begin
                bus.req_rs[0] = t3_cmd[i+1][8];
                bus.req_data[7:0] = t3_cmd[i+1][7:0];
                wait_send(40, n);
                chk("t3_gap_to_send", n, t3_gap[i] + 1);
            end else begin
                bus.req = '0;
                wait_idle(40, n);
                chk("t3_gap_to_idle", n, t3_gap[i]);
            end
        end

        // 4: late drop still served, early drop never served
        bus.req_data[23:16] = 8'h55;
        bus.req_rs[2] = 1'b1;
        bus.req = 3'b100;
        wait_send(10, n);
        chk("t4_send_lat", n, 1);
        chk("t4_grant", bus.grant_id, 2);
        bus.req = '0;
        bus.req_data[23:16] = 8'hAA;
        tick();
        chk("t4_data_hold", bus.lcd_data, 8'h55);
        wait_ack(10, n);
        chk("t4_ack_lat", n, 3);
        chk("t4_ack", bus.ack, 3'b100);
        bus.req_data[7:0] = 8'h77;
        bus.req_rs[0] = 1'b1;
        bus.req = 3'b001;
        tick();
        bus.req = '0;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.lcd_send === 1'b1) cnt++;
        end
        chk("t4_early_drop_sends", cnt, 0);

        // 5: reset during WAIT_DONE
        bus.req_data[7:0] = 8'h48;
        bus.req = 3'b001;
        wait_send(10, n);
        chk("t5_send_lat", n, 1);
        tick();
        reset = 1'b1;
        bus.req = 3'b100;
        bus.req_data[23:16] = 8'h62;
        #1;
        chk("t5_busy", bus.busy, 0);
        chk("t5_data", bus.lcd_data, 0);
        chk("t5_grant", bus.grant_id, 0);
        chk("t5_send", bus.lcd_send, 0);
        chk("t5_rs", bus.lcd_rs, 0);
        @(posedge clk);
        #1;
        chk("t5_no_ack", bus.ack, 0);
        reset = 1'b0;
        wait_send(10, n);
        chk("t5_send2_lat", n, 1);
        chk("t5_grant2", bus.grant_id, 2);
        chk("t5_data2", bus.lcd_data, 8'h62);
        wait_ack(10, n);
        chk("t5_ack_lat", n, 4);
        chk("t5_ack", bus.ack, 3'b100);
        bus.req = '0;
        wait_idle(40, n);
        chk("t5_idle", n > 0, 1);

        // 6: controller never answers
        ctrl_en = 1'b0;
        bus.req_data[15:8] = 8'h20;
        bus.req_rs[1] = 1'b1;
        bus.req = 3'b010;
        wait_send(10, n);
        chk("t6_send_lat", n, 1);
`ifdef LCD_ARB_TIMEOUT_EN
        wait_ack(80, n);
        chk("t6_tmo_ack_lat", n, 51);
        chk("t6_tmo_ack", bus.ack, 3'b010);
        chk("t6_tmo_err", bus.timeout_err, 1);
        bus.req = '0;
        wait_idle(40, n);
        chk("t6_long_gap", n, 20);
        tick();
        chk("t6_tmo_sticky", bus.timeout_err, 1);
`else
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (bus.ack !== 3'b000) cnt++;
        end
        chk("t6_no_ack", cnt, 0);
        chk("t6_busy_hold", bus.busy, 1);
        chk("t6_tmo_err", bus.timeout_err, 0);
        bus.req = '0;
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
